// File: rtl/cpu_pkg.sv
// Shared opcode encodings and word width for the mini-CPU datapath.
// Constants only; no logic, no latency, no backpressure.
package cpu_pkg;

   localparam int WORD_W = 32;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_SHR  = 5'b00100;
   localparam logic [4:0] OP_SHRA = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_MUL  = 5'b01001;
   localparam logic [4:0] OP_DIV  = 5'b01010;
   localparam logic [4:0] OP_NEG  = 5'b01011;
   localparam logic [4:0] OP_NOT  = 5'b01100;

endpackage

// File: rtl/cpu_alu.sv
// ALU, A = Y and B = bus, 64-bit {hi, lo} result; purely combinational, no backpressure.
// DATAPATH_MULDIV_EN adds the signed multiplier/divider; otherwise mul/div return 0.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [WORD_W-1:0]   a,
   input  logic [WORD_W-1:0]   b,
   input  logic [4:0]          op,
   output logic [2*WORD_W-1:0] result
);

   logic [4:0]          sh;
   logic [2*WORD_W-1:0] rot_r;
   logic [2*WORD_W-1:0] rot_l;

   // Rotating a doubled word turns rotates into plain shifts.
   assign sh    = b[4:0];
   assign rot_r = {a, a} >> sh;
   assign rot_l = {a, a} << sh;

`ifdef DATAPATH_MULDIV_EN
   logic signed [2*WORD_W-1:0] prod;
   logic        [WORD_W-1:0]   divisor;
   logic signed [WORD_W-1:0]   quo;
   logic signed [WORD_W-1:0]   rem;

   assign prod    = $signed({{WORD_W{a[WORD_W-1]}}, a}) * $signed({{WORD_W{b[WORD_W-1]}}, b});
   assign divisor = (b == '0) ? {{(WORD_W-1){1'b0}}, 1'b1} : b;
   assign quo     = $signed(a) / $signed(divisor);
   assign rem     = $signed(a) % $signed(divisor);
`endif

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result[WORD_W-1:0] = a + b;
         OP_SUB:  result[WORD_W-1:0] = a - b;
         OP_AND:  result[WORD_W-1:0] = a & b;
         OP_OR:   result[WORD_W-1:0] = a | b;
         OP_SHR:  result[WORD_W-1:0] = a >> sh;
         OP_SHRA: result[WORD_W-1:0] = $signed(a) >>> sh;
         OP_SHL:  result[WORD_W-1:0] = a << sh;
         OP_ROR:  result[WORD_W-1:0] = rot_r[WORD_W-1:0];
         OP_ROL:  result[WORD_W-1:0] = rot_l[2*WORD_W-1:WORD_W];
`ifdef DATAPATH_MULDIV_EN
         OP_MUL:  result = prod;
         OP_DIV: begin
            if (b == '0) result = {a, {WORD_W{1'b1}}};
            else         result = {rem, quo};
         end
`endif
         OP_NEG:  result[WORD_W-1:0] = '0 - b;
         OP_NOT:  result[WORD_W-1:0] = ~b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/cpu_data_path.sv
// Single-bus 32-bit datapath: registers load from the bus (or ALU for Z) in one cycle; no backpressure.
// Optional signed mul/div enabled by DATAPATH_MULDIV_EN (see cpu_alu).
module cpu_data_path
   import cpu_pkg::*;
(
   input  logic        Clock,
   input  logic        clear,
   input  logic        Read,
   input  logic [4:0]  op,
   input  logic [31:0] Mdatain,
   input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
   input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
   input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
   input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        Zhighout,
   input  logic        Zlowout,
   input  logic        PCout,
   input  logic        MDRout,
   input  logic        InPortout,
   input  logic        Yout,
   input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
   input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
   input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
   input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        ZHighin,
   input  logic        Zlowin,
   input  logic        IncPC,
   input  logic        MDRin,
   input  logic        InPortin,
   input  logic        Yin,
   output logic [31:0] BusOut,
   output logic [31:0] mdrData,
   output logic [31:0] BusMuxInR0,
   output logic [31:0] BusMuxInR1,
   output logic [31:0] BusMuxInR2,
   output logic [31:0] BusMuxInYOut,
   output logic [31:0] BusMuxInHI,
   output logic [31:0] BusMuxInLO
);

   logic [15:0]         r_out;
   logic [15:0]         r_in;
   logic [WORD_W-1:0]   gpr [16];
   logic [WORD_W-1:0]   hi, lo, z_high, z_low, pc, mdr, in_port, y;
   logic [WORD_W-1:0]   bus;
   logic [2*WORD_W-1:0] alu_res;

   assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
   assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

   // Lowest-priority source is assigned first so that later hits override: R0 wins last.
   always_comb begin
      bus = '0;
      if (Yout)      bus = y;
      if (InPortout) bus = in_port;
      if (MDRout)    bus = mdr;
      if (PCout)     bus = pc;
      if (Zlowout)   bus = z_low;
      if (Zhighout)  bus = z_high;
      if (LOout)     bus = lo;
      if (HIout)     bus = hi;
      for (int i = 15; i >= 0; i--) begin
         if (r_out[i]) bus = gpr[i];
      end
   end

   cpu_alu u_alu (
      .a      (y),
      .b      (bus),
      .op     (op),
      .result (alu_res)
   );

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
         hi      <= '0;
         lo      <= '0;
         z_high  <= '0;
         z_low   <= '0;
         pc      <= '0;
         mdr     <= '0;
         in_port <= '0;
         y       <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (r_in[i]) gpr[i] <= bus;
         end
         if (HIin)     hi      <= bus;
         if (LOin)     lo      <= bus;
         if (ZHighin)  z_high  <= alu_res[2*WORD_W-1:WORD_W];
         if (Zlowin)   z_low   <= alu_res[WORD_W-1:0];
         if (IncPC)    pc      <= pc + 32'd1;
         if (MDRin)    mdr     <= Read ? Mdatain : bus;
         if (InPortin) in_port <= bus;
         if (Yin)      y       <= bus;
      end
   end

   assign BusOut       = bus;
   assign mdrData      = mdr;
   assign BusMuxInR0   = gpr[0];
   assign BusMuxInR1   = gpr[1];
   assign BusMuxInR2   = gpr[2];
   assign BusMuxInYOut = y;
   assign BusMuxInHI   = hi;
   assign BusMuxInLO   = lo;

endmodule

// File: tb/tb_cpu_data_path.sv
// Scoreboard bench for cpu_data_path: stimulus pushes expected values, a monitor pops and compares.
module tb_cpu_data_path;

   localparam int X_HI = 16, X_LO = 17, X_ZH = 18, X_ZL = 19;
   localparam int X_PC = 20, X_MDR = 21, X_IN = 22, X_Y = 23;
   localparam int S_BUS = 0, S_MDR = 1, S_R0 = 2, S_R1 = 3, S_R2 = 4, S_Y = 5, S_HI = 6, S_LO = 7;

   logic        Clock = 1'b0;
   logic        clear;
   logic        Read;
   logic [4:0]  op;
   logic [31:0] Mdatain;
   logic [23:0] om, im;
   logic [31:0] BusOut, mdrData, BusMuxInR0, BusMuxInR1, BusMuxInR2;
   logic [31:0] BusMuxInYOut, BusMuxInHI, BusMuxInLO;

   always #5 Clock = ~Clock;

   cpu_data_path dut (
      .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
      .R0out(om[0]),   .R1out(om[1]),   .R2out(om[2]),   .R3out(om[3]),
      .R4out(om[4]),   .R5out(om[5]),   .R6out(om[6]),   .R7out(om[7]),
      .R8out(om[8]),   .R9out(om[9]),   .R10out(om[10]), .R11out(om[11]),
      .R12out(om[12]), .R13out(om[13]), .R14out(om[14]), .R15out(om[15]),
      .HIout(om[X_HI]), .LOout(om[X_LO]), .Zhighout(om[X_ZH]), .Zlowout(om[X_ZL]),
      .PCout(om[X_PC]), .MDRout(om[X_MDR]), .InPortout(om[X_IN]), .Yout(om[X_Y]),
      .R0in(im[0]),   .R1in(im[1]),   .R2in(im[2]),   .R3in(im[3]),
      .R4in(im[4]),   .R5in(im[5]),   .R6in(im[6]),   .R7in(im[7]),
      .R8in(im[8]),   .R9in(im[9]),   .R10in(im[10]), .R11in(im[11]),
      .R12in(im[12]), .R13in(im[13]), .R14in(im[14]), .R15in(im[15]),
      .HIin(im[X_HI]), .LOin(im[X_LO]), .ZHighin(im[X_ZH]), .Zlowin(im[X_ZL]),
      .IncPC(im[X_PC]), .MDRin(im[X_MDR]), .InPortin(im[X_IN]), .Yin(im[X_Y]),
      .BusOut(BusOut), .mdrData(mdrData), .BusMuxInR0(BusMuxInR0), .BusMuxInR1(BusMuxInR1),
      .BusMuxInR2(BusMuxInR2), .BusMuxInYOut(BusMuxInYOut), .BusMuxInHI(BusMuxInHI),
      .BusMuxInLO(BusMuxInLO)
   );

   // Reference state
   logic [31:0] m_r [16];
   logic [31:0] m_hi, m_lo, m_zh, m_zl, m_pc, m_mdr, m_in, m_y;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;
   chk_t sb[$];

   int checks = 0;
   int errors = 0;

   function automatic logic [23:0] bit24(input int i);
      logic [23:0] one;
      one = 24'd1;
      return one << i;
   endfunction

   function automatic logic [31:0] dut_sig(input int sel);
      case (sel)
         S_BUS:   return BusOut;
         S_MDR:   return mdrData;
         S_R0:    return BusMuxInR0;
         S_R1:    return BusMuxInR1;
         S_R2:    return BusMuxInR2;
         S_Y:     return BusMuxInYOut;
         S_HI:    return BusMuxInHI;
         default: return BusMuxInLO;
      endcase
   endfunction

   function automatic logic [31:0] model_bus(input logic [23:0] m);
      for (int i = 0; i < 16; i++) if (m[i]) return m_r[i];
      if (m[X_HI])  return m_hi;
      if (m[X_LO])  return m_lo;
      if (m[X_ZH])  return m_zh;
      if (m[X_ZL])  return m_zl;
      if (m[X_PC])  return m_pc;
      if (m[X_MDR]) return m_mdr;
      if (m[X_IN])  return m_in;
      if (m[X_Y])   return m_y;
      return 32'd0;
   endfunction

   // Bit-level / integer-arithmetic definition of each operation.
   function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [4:0] o);
      logic [31:0] lo, hi;
      int s, sa, sb_v;
      longint p;
      lo = 32'd0; hi = 32'd0;
      s = int'(b[4:0]);
      sa = int'(a); sb_v = int'(b);
      case (o)
         5'd0: lo = a + b;
         5'd1: lo = a - b;
         5'd2: lo = a & b;
         5'd3: lo = a | b;
         5'd4: for (int i = 0; i < 32; i++) if (i + s < 32) lo[i] = a[i+s];
         5'd5: for (int i = 0; i < 32; i++) begin
                  if (i + s < 32) lo[i] = a[i+s]; else lo[i] = a[31];
               end
         5'd6: for (int i = 0; i < 32; i++) if (i >= s) lo[i] = a[i-s];
         5'd7: for (int i = 0; i < 32; i++) lo[i] = a[(i+s)%32];
         5'd8: for (int i = 0; i < 32; i++) lo[(i+s)%32] = a[i];
`ifdef DATAPATH_MULDIV_EN
         5'd9: begin
            p = longint'(sa) * longint'(sb_v);
            hi = p[63:32];
            lo = p[31:0];
         end
         5'd10: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               lo = sa / sb_v;
               hi = sa % sb_v;
            end
         end
`endif
         5'd11: lo = 32'd0 - b;
         5'd12: lo = ~b;
         default: ;
      endcase
      return {hi, lo};
   endfunction

   task automatic push(input string n, input int sel, input logic [31:0] e);
      sb.push_back('{n, sel, e});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
      m_hi = 0; m_lo = 0; m_zh = 0; m_zl = 0; m_pc = 0; m_mdr = 0; m_in = 0; m_y = 0;
   endtask

   // One clock of control; the bus value is checked in the same cycle.
   task automatic cyc(input logic [23:0] o_m, input logic [23:0] i_m, input logic rd,
                      input logic [31:0] md, input logic [4:0] opc);
      logic [31:0] bus;
      logic [63:0] z;
      @(negedge Clock);
      om = o_m; im = i_m; Read = rd; Mdatain = md; op = opc;
      bus = model_bus(o_m);
      z = alu_ref(m_y, bus, opc);
      push("bus", S_BUS, bus);
      for (int i = 0; i < 16; i++) if (i_m[i]) m_r[i] = bus;
      if (i_m[X_HI])  m_hi = bus;
      if (i_m[X_LO])  m_lo = bus;
      if (i_m[X_ZH])  m_zh = z[63:32];
      if (i_m[X_ZL])  m_zl = z[31:0];
      if (i_m[X_PC])  m_pc = m_pc + 32'd1;
      if (i_m[X_MDR]) m_mdr = rd ? md : bus;
      if (i_m[X_IN])  m_in = bus;
      if (i_m[X_Y])   m_y = bus;
   endtask

   task automatic chk(input string n, input int sel, input logic [31:0] e);
      @(negedge Clock);
      om = '0; im = '0; Read = 1'b0;
      push(n, sel, e);
   endtask

   task automatic do_reset();
      @(negedge Clock);
      clear = 1'b0;
      om = '0; im = '0; Read = 1'b0;
      model_reset();
      for (int s = 0; s < 8; s++) push("reset", s, 32'd0);
      @(negedge Clock);
      clear = 1'b1;
   endtask

   task automatic load_y(input logic [31:0] v);
      cyc('0, bit24(X_MDR), 1'b1, v, 5'd0);
      cyc(bit24(X_MDR), bit24(X_Y), 1'b0, 32'd0, 5'd0);
   endtask

   task automatic load_r(input int r, input logic [31:0] v);
      cyc('0, bit24(X_MDR), 1'b1, v, 5'd0);
      cyc(bit24(X_MDR), bit24(r), 1'b0, 32'd0, 5'd0);
   endtask

   // Y op R2 into Z, then ZLow -> R1 and ZHigh -> R0.
   task automatic run_op(input logic [4:0] opc, input logic [23:0] zmask);
      cyc(bit24(2), zmask, 1'b0, 32'd0, opc);
      cyc(bit24(X_ZL), bit24(1), 1'b0, 32'd0, 5'd0);
      cyc(bit24(X_ZH), bit24(0), 1'b0, 32'd0, 5'd0);
   endtask

   initial begin : monitor
      chk_t c;
      logic [31:0] act;
      forever begin
         @(negedge Clock);
         #2;
         while (sb.size() > 0) begin
            c = sb.pop_front();
            act = dut_sig(c.sel);
            checks++;
            if (act !== c.exp) begin
               errors++;
               $display("FAIL %s sel=%0d got %h expected %h at %0t", c.name, c.sel, act, c.exp, $time);
            end
         end
      end
   end

   initial begin : stim
      logic [23:0] zboth;
      logic [31:0] a, b;
      logic [4:0]  o;
      zboth = bit24(X_ZH) | bit24(X_ZL);
      clear = 1'b0; om = '0; im = '0; Read = 1'b0; op = '0; Mdatain = '0;
      model_reset();

      do_reset();
      cyc('0, '0, 1'b0, 32'd0, 5'd0);

      // shra of -12 by 5
      load_y(32'hFFFF_FFF4);
      load_r(2, 32'd5);
      run_op(5'b00101, zboth);
      chk("shra_lo", S_R1, 32'hFFFF_FFFF);
      chk("shra_hi", S_R0, 32'd0);
      chk("shra_y",  S_Y,  32'hFFFF_FFF4);
      chk("shra_r2", S_R2, 32'd5);

      load_y(32'd7);
      load_r(2, 32'd9);
      run_op(5'b00000, zboth);
      chk("add", S_R1, 32'd16);
      run_op(5'b00001, zboth);
      chk("sub", S_R1, 32'hFFFF_FFFE);

`ifdef DATAPATH_MULDIV_EN
      load_y(32'h0001_0000);
      load_r(2, 32'h0001_0000);
      run_op(5'b01001, zboth);
      chk("mul_hi", S_R0, 32'd1);
      chk("mul_lo", S_R1, 32'd0);
      load_y(32'hFFFF_FFF9);
      load_r(2, 32'd2);
      run_op(5'b01010, zboth);
      chk("div_q", S_R1, 32'hFFFF_FFFD);
      chk("div_r", S_R0, 32'hFFFF_FFFF);
      load_r(2, 32'd0);
      run_op(5'b01010, zboth);
      chk("div0_q", S_R1, 32'hFFFF_FFFF);
      chk("div0_r", S_R0, 32'hFFFF_FFF9);
`else
      load_y(32'h0001_0000);
      load_r(2, 32'h0001_0000);
      run_op(5'b01001, zboth);
      chk("mul_off_lo", S_R1, 32'd0);
      chk("mul_off_hi", S_R0, 32'd0);
`endif

      // Bus priority, MDR from bus, PC increment
      load_r(2, 32'd5);
      load_r(0, 32'h0000_1234);
      cyc(bit24(0) | bit24(2), bit24(1), 1'b0, 32'd0, 5'd0);
      chk("prio", S_R1, 32'h0000_1234);
      cyc(bit24(0), bit24(X_MDR), 1'b0, 32'hDEAD_BEEF, 5'd0);
      chk("mdr_bus", S_MDR, 32'h0000_1234);
      for (int i = 0; i < 3; i++) cyc('0, bit24(X_PC), 1'b0, 32'd0, 5'd0);
      cyc(bit24(X_PC), bit24(1), 1'b0, 32'd0, 5'd0);
      chk("pc3", S_R1, 32'd3);

      // Mid-sequence clear
      load_r(2, 32'd77);
      do_reset();

      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
         if ($urandom_range(0, 1) == 1) b = -b;
         o = 5'($urandom_range(0, 15));
         if (o == 5'd10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         load_y(a);
         load_r(2, b);
         run_op(o, (bit24(X_ZH) & {24{$urandom_range(0, 2) != 0}}) |
                   (bit24(X_ZL) & {24{$urandom_range(0, 2) != 0}}));
         cyc(bit24(2), bit24(X_HI) | bit24(X_IN), 1'b0, 32'd0, 5'd0);
         cyc(bit24(X_IN), bit24(X_LO), 1'b0, 32'd0, 5'd0);
         chk("rnd_r1", S_R1, m_r[1]);
         chk("rnd_r0", S_R0, m_r[0]);
         chk("rnd_hi", S_HI, m_hi);
         chk("rnd_lo", S_LO, m_lo);
      end

      @(negedge Clock);
      @(negedge Clock);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
